riscv_core_rob_retire: RTL and testbench
========================================

Name: riscv_core_rob_retire

Overview:
- Result-side counterpart of the 2-wide reorder buffer. It accepts up to two execute writebacks per cycle into a 32-entry slot-indexed result buffer and raises the ROB completion requests.
- It consumes the ROB's two in-order commit outputs and drives the two architectural register-file write ports, registered one cycle later.
- It also serves renamed-operand lookups for issue, i.e. reads of the buffer by ROB slot.

Parameters:
- NSLOTS, 32, number of ROB slots and result-buffer entries; power of two.
- SLOT_W, 5, slot index width, equal to log2(NSLOTS).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wb_val_A / wb_val_B  in  1  writeback valid, execute pipe A / pipe B
- wb_slot_A / wb_slot_B  in  SLOT_W  ROB slot being completed
- wb_data_A / wb_data_B  in  XLEN  result value
- rob_commit_req_A / rob_commit_req_B  out  1  completion pulse to ROB
- rob_commit_slot_A / rob_commit_slot_B  out  SLOT_W  completed slot
- cm_ready_A / cm_ready_B  in  1  ROB head / head+1 retiring this cycle
- cm_slot_A / cm_slot_B  in  SLOT_W  retiring slot
- cm_rd_A / cm_rd_B  in  5  destination architectural register
- cm_we_A / cm_we_B  in  1  retiring instruction writes rd
- cm_spec_A / cm_spec_B  in  1  entry squashed (still speculative at retire)
- rf_wen_A / rf_wen_B  out  1  register-file write enable (registered)
- rf_waddr_A / rf_waddr_B  out  5  register-file write address
- rf_wdata_A / rf_wdata_B  out  XLEN  register-file write data
- op_slot_0 .. op_slot_3  in  SLOT_W  renamed-source lookup slot
- op_done_0 .. op_done_3  out  1  slot result present
- op_data_0 .. op_data_3  out  XLEN  slot result (forwarded)

Behaviour:
- State:
  - data[NSLOTS] (XLEN each)
  - done[NSLOTS] (1 bit each)
  - registered rf_* outputs
- Reset (reset=0, asynchronous):
  - done <= 0; all rf_wen/rf_waddr/rf_wdata <= 0.
  - rob_commit_req_* read 0 while reset is low.
  - data contents are not reset.
- Writeback (edge):
  - wb_val_X=1 writes data[wb_slot_X] <= wb_data_X and sets done[wb_slot_X] <= 1.
  - rob_commit_req_X = wb_val_X and rob_commit_slot_X = wb_slot_X, combinationally, same cycle; the ROB flips its pending bit at the same edge.
  - If both pipes write the same slot in one cycle, pipe B wins for data; both completion pulses are still issued.
- Retire:
  - Retire A is eligible when cm_ready_A=1; retire B when cm_ready_B=1.
  - A retiring slot clears done at the edge.
  - Write qualification: q_X = cm_ready_X & cm_we_X & !cm_spec_X & (cm_rd_X != 0).
  - At the edge: rf_wen_X <= q_X; rf_waddr_X <= cm_rd_X; rf_wdata_X <= data[cm_slot_X] (value before this edge's writes).
  - Retire-to-register-file latency is 1 cycle. rf_wen is a single-cycle pulse per retire.
  - cm_ready_B without cm_ready_A cannot occur; if it does, it is treated as B-only.
- Simultaneous writeback and retire on the same slot (slot reallocated):
  - The writeback's set of done wins.
  - The retire reads the old data.
- A squashed entry (cm_spec_X=1) retires silently: done is cleared, no register-file write.
- Operand lookup (combinational):
  - op_done_k = done[op_slot_k] | (wb_val_A & wb_slot_A==op_slot_k) | (wb_val_B & wb_slot_B==op_slot_k).
  - op_data_k forward priority: wb B, then wb A, then data[op_slot_k].
- Wrap-around: slot indices are modulo NSLOTS; no pointer arithmetic is held here.

Optional Feature:
- Macro: RISCV_RETIRE_INSTRET_EN.
- When defined: adds output instret (64 bits).
  - Resets to 0.
  - Increments at each edge by (cm_ready_A & !cm_spec_A) + (cm_ready_B & !cm_spec_B), i.e. 0, 1 or 2.
  - Wraps modulo 2^64.
- When undefined: no port and no counter; all other behaviour is identical.

Decomposition:
- Shared package riscv_core_pkg:
  - NSLOTS, SLOT_W, XLEN.
  - Typedef slot_t.
  - Typedef xword_t.
- One sub-module, riscv_core_result_buf: 2-write, 6-read, slot-indexed data/done array with wb forwarding on the 4 operand reads. The top level holds retire qualification, output registers and the optional counter.

Test Plan:
- Reset mid-run: drive done bits, pull reset low between edges → done=0 and rf_wen_A/B=0 immediately; after release, op_done_0 for slot 3 =0.
- Writeback then retire:
  - Cycle 0: wb_val_A, slot 4, data 0xDEADBEEF → rob_commit_req_A=1, rob_commit_slot_A=4 in the same cycle.
  - Cycle 2: cm_ready_A, slot 4, rd 7, we=1 → cycle 3: rf_wen_A=1, waddr=7, wdata=0xDEADBEEF; done[4]=0.
- Dual retire: slots 30 and 31 hold 0x11 and 0x22; cm_ready_A/B with rd 5/6 → next cycle both rf_wen=1 with matching addresses and data; instret +2 (when enabled).
- Squash and x0:
  - cm_spec_A=1, we=1, rd 9 → rf_wen_A=0, instret +0.
  - cm_spec_A=0, we=1, rd 0 → rf_wen_A=0, instret +1.
- Forwarding: wb_val_B slot 12 data 0x55 while op_slot_2=12 → op_done_2=1 and op_data_2=0x55 in the same cycle.
- Slot collision: wb_val_A and wb_val_B both slot 8, data 0xA and 0xB → data[8]=0xB, both rob_commit_req pulses are issued.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared types and sizes for the ROB result-side blocks (result buffer and retire stage).
package riscv_core_pkg;

  localparam int unsigned NSLOTS  = 32;
  localparam int unsigned SLOT_W  = $clog2(NSLOTS);
  localparam int unsigned XLEN    = 32;
  localparam int unsigned NOPS    = 4;
  localparam int unsigned RADDR_W = 5;

  typedef logic [SLOT_W-1:0]  slot_t;
  typedef logic [XLEN-1:0]    xword_t;
  typedef logic [RADDR_W-1:0] areg_t;

  // One execute-pipe writeback into the result buffer
  typedef struct packed {
    logic   valid;
    slot_t  slot;
    xword_t data;
  } wb_t;

endpackage

// File: rtl/riscv_core_result_buf.sv
// Slot-indexed result buffer: two writebacks, two retire reads, four forwarded operand reads.
module riscv_core_result_buf
  import riscv_core_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  wb_t    wb_a,
  input  wb_t    wb_b,
  input  logic   clr_a,
  input  slot_t  clr_slot_a,
  input  logic   clr_b,
  input  slot_t  clr_slot_b,
  input  slot_t  op_slot [NOPS],
  output logic   op_done_c [NOPS],
  output xword_t op_data_c [NOPS],
  output xword_t rt_data_a_c,
  output xword_t rt_data_b_c
);

  logic [NSLOTS-1:0] done_q;
  xword_t            data_q [NSLOTS];

  // Retire clears first so a same-edge writeback to a reallocated slot keeps done set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= '0;
    end else begin
      if (clr_a)      done_q[clr_slot_a] <= 1'b0;
      if (clr_b)      done_q[clr_slot_b] <= 1'b0;
      if (wb_a.valid) done_q[wb_a.slot]  <= 1'b1;
      if (wb_b.valid) done_q[wb_b.slot]  <= 1'b1;
    end
  end

  // Data is not reset; pipe B is written last so it wins a same-slot collision
  always_ff @(posedge clk) begin
    if (wb_a.valid) data_q[wb_a.slot] <= wb_a.data;
    if (wb_b.valid) data_q[wb_b.slot] <= wb_b.data;
  end

  assign rt_data_a_c = data_q[clr_slot_a];
  assign rt_data_b_c = data_q[clr_slot_b];

  // Operand lookup with writeback bypass, pipe B highest priority
  always_comb begin
    for (int k = 0; k < NOPS; k++) begin
      op_done_c[k] = done_q[op_slot[k]];
      op_data_c[k] = data_q[op_slot[k]];
      if (wb_a.valid && (wb_a.slot == op_slot[k])) begin
        op_done_c[k] = 1'b1;
        op_data_c[k] = wb_a.data;
      end
      if (wb_b.valid && (wb_b.slot == op_slot[k])) begin
        op_done_c[k] = 1'b1;
        op_data_c[k] = wb_b.data;
      end
    end
  end

endmodule

// File: rtl/riscv_core_rob_retire.sv
// ROB result side: writeback capture, completion requests, in-order register-file retire.
// Optional instret counter enabled by defining RISCV_RETIRE_INSTRET_EN.
module riscv_core_rob_retire
  import riscv_core_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   wb_val_A,
  input  slot_t  wb_slot_A,
  input  xword_t wb_data_A,
  input  logic   wb_val_B,
  input  slot_t  wb_slot_B,
  input  xword_t wb_data_B,
  output logic   rob_commit_req_A,
  output slot_t  rob_commit_slot_A,
  output logic   rob_commit_req_B,
  output slot_t  rob_commit_slot_B,
  input  logic   cm_ready_A,
  input  slot_t  cm_slot_A,
  input  areg_t  cm_rd_A,
  input  logic   cm_we_A,
  input  logic   cm_spec_A,
  input  logic   cm_ready_B,
  input  slot_t  cm_slot_B,
  input  areg_t  cm_rd_B,
  input  logic   cm_we_B,
  input  logic   cm_spec_B,
  output logic   rf_wen_A,
  output areg_t  rf_waddr_A,
  output xword_t rf_wdata_A,
  output logic   rf_wen_B,
  output areg_t  rf_waddr_B,
  output xword_t rf_wdata_B,
  input  slot_t  op_slot_0,
  input  slot_t  op_slot_1,
  input  slot_t  op_slot_2,
  input  slot_t  op_slot_3,
  output logic   op_done_0,
  output logic   op_done_1,
  output logic   op_done_2,
  output logic   op_done_3,
  output xword_t op_data_0,
  output xword_t op_data_1,
  output xword_t op_data_2,
  output xword_t op_data_3
`ifdef RISCV_RETIRE_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  wb_t    wb_a_c, wb_b_c;
  slot_t  op_slot_c [NOPS];
  logic   op_done_c [NOPS];
  xword_t op_data_c [NOPS];
  xword_t rt_data_a_c, rt_data_b_c;
  logic   q_a_c, q_b_c;

  assign wb_a_c = '{valid: wb_val_A, slot: wb_slot_A, data: wb_data_A};
  assign wb_b_c = '{valid: wb_val_B, slot: wb_slot_B, data: wb_data_B};

  assign op_slot_c[0] = op_slot_0;
  assign op_slot_c[1] = op_slot_1;
  assign op_slot_c[2] = op_slot_2;
  assign op_slot_c[3] = op_slot_3;

  riscv_core_result_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .wb_a        (wb_a_c),
    .wb_b        (wb_b_c),
    .clr_a       (cm_ready_A),
    .clr_slot_a  (cm_slot_A),
    .clr_b       (cm_ready_B),
    .clr_slot_b  (cm_slot_B),
    .op_slot     (op_slot_c),
    .op_done_c   (op_done_c),
    .op_data_c   (op_data_c),
    .rt_data_a_c (rt_data_a_c),
    .rt_data_b_c (rt_data_b_c)
  );

  assign op_done_0 = op_done_c[0];
  assign op_done_1 = op_done_c[1];
  assign op_done_2 = op_done_c[2];
  assign op_done_3 = op_done_c[3];
  assign op_data_0 = op_data_c[0];
  assign op_data_1 = op_data_c[1];
  assign op_data_2 = op_data_c[2];
  assign op_data_3 = op_data_c[3];

  // Completion pulses are combinational and held off while reset is asserted
  assign rob_commit_req_A  = wb_val_A & reset;
  assign rob_commit_req_B  = wb_val_B & reset;
  assign rob_commit_slot_A = wb_slot_A;
  assign rob_commit_slot_B = wb_slot_B;

  assign q_a_c = cm_ready_A & cm_we_A & ~cm_spec_A & (cm_rd_A != '0);
  assign q_b_c = cm_ready_B & cm_we_B & ~cm_spec_B & (cm_rd_B != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wen_A   <= 1'b0;
      rf_waddr_A <= '0;
      rf_wdata_A <= '0;
      rf_wen_B   <= 1'b0;
      rf_waddr_B <= '0;
      rf_wdata_B <= '0;
    end else begin
      rf_wen_A   <= q_a_c;
      rf_waddr_A <= cm_rd_A;
      rf_wdata_A <= rt_data_a_c;
      rf_wen_B   <= q_b_c;
      rf_waddr_B <= cm_rd_B;
      rf_wdata_B <= rt_data_b_c;
    end
  end

`ifdef RISCV_RETIRE_INSTRET_EN
  logic [1:0] ret_cnt_c;

  // Squashed entries retire but are not counted as instructions
  assign ret_cnt_c = 2'(cm_ready_A & ~cm_spec_A) + 2'(cm_ready_B & ~cm_spec_B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret <= '0;
    else        instret <= instret + 64'(ret_cnt_c);
  end
`endif

endmodule

// File: tb/tb_riscv_core_rob_retire.sv
// Bench for riscv_core_rob_retire: directed scenarios plus random traffic against an array model.
module tb_riscv_core_rob_retire;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_val_A, wb_val_B;
  logic [4:0]  wb_slot_A, wb_slot_B;
  logic [31:0] wb_data_A, wb_data_B;
  logic        rob_commit_req_A, rob_commit_req_B;
  logic [4:0]  rob_commit_slot_A, rob_commit_slot_B;
  logic        cm_ready_A, cm_ready_B, cm_we_A, cm_we_B, cm_spec_A, cm_spec_B;
  logic [4:0]  cm_slot_A, cm_slot_B, cm_rd_A, cm_rd_B;
  logic        rf_wen_A, rf_wen_B;
  logic [4:0]  rf_waddr_A, rf_waddr_B;
  logic [31:0] rf_wdata_A, rf_wdata_B;
  logic [4:0]  op_slot [4];
  logic        op_done [4];
  logic [31:0] op_data [4];
`ifdef RISCV_RETIRE_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_data  [32];
  bit          m_valid [32];
  bit          m_done  [32];
  logic [63:0] m_instret;
  logic        e_wen_a, e_wen_b;
  logic [4:0]  e_waddr_a, e_waddr_b;
  logic [31:0] e_wdata_a, e_wdata_b;
  bit          e_wdata_a_ok, e_wdata_b_ok;

  always #5 clk = ~clk;

  riscv_core_rob_retire dut (
    .clk(clk), .reset(reset),
    .wb_val_A(wb_val_A), .wb_slot_A(wb_slot_A), .wb_data_A(wb_data_A),
    .wb_val_B(wb_val_B), .wb_slot_B(wb_slot_B), .wb_data_B(wb_data_B),
    .rob_commit_req_A(rob_commit_req_A), .rob_commit_slot_A(rob_commit_slot_A),
    .rob_commit_req_B(rob_commit_req_B), .rob_commit_slot_B(rob_commit_slot_B),
    .cm_ready_A(cm_ready_A), .cm_slot_A(cm_slot_A), .cm_rd_A(cm_rd_A),
    .cm_we_A(cm_we_A), .cm_spec_A(cm_spec_A),
    .cm_ready_B(cm_ready_B), .cm_slot_B(cm_slot_B), .cm_rd_B(cm_rd_B),
    .cm_we_B(cm_we_B), .cm_spec_B(cm_spec_B),
    .rf_wen_A(rf_wen_A), .rf_waddr_A(rf_waddr_A), .rf_wdata_A(rf_wdata_A),
    .rf_wen_B(rf_wen_B), .rf_waddr_B(rf_waddr_B), .rf_wdata_B(rf_wdata_B),
    .op_slot_0(op_slot[0]), .op_slot_1(op_slot[1]), .op_slot_2(op_slot[2]), .op_slot_3(op_slot[3]),
    .op_done_0(op_done[0]), .op_done_1(op_done[1]), .op_done_2(op_done[2]), .op_done_3(op_done[3]),
    .op_data_0(op_data[0]), .op_data_1(op_data[1]), .op_data_2(op_data[2]), .op_data_3(op_data[3])
`ifdef RISCV_RETIRE_INSTRET_EN
    , .instret(instret)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_val_A = 0; wb_slot_A = 0; wb_data_A = 0;
    wb_val_B = 0; wb_slot_B = 0; wb_data_B = 0;
    cm_ready_A = 0; cm_slot_A = 0; cm_rd_A = 0; cm_we_A = 0; cm_spec_A = 0;
    cm_ready_B = 0; cm_slot_B = 0; cm_rd_B = 0; cm_we_B = 0; cm_spec_B = 0;
  endtask

  // Check the combinational outputs against the model for the current inputs
  task automatic settle();
    logic        d;
    logic [31:0] v;
    bit          known;
    #1;
    check("req_A", 64'(rob_commit_req_A), 64'(wb_val_A));
    check("req_B", 64'(rob_commit_req_B), 64'(wb_val_B));
    if (wb_val_A) check("slot_A", 64'(rob_commit_slot_A), 64'(wb_slot_A));
    if (wb_val_B) check("slot_B", 64'(rob_commit_slot_B), 64'(wb_slot_B));
    for (int k = 0; k < 4; k++) begin
      d = m_done[op_slot[k]];
      v = m_data[op_slot[k]];
      known = m_valid[op_slot[k]];
      if (wb_val_A && wb_slot_A == op_slot[k]) begin d = 1; v = wb_data_A; known = 1; end
      if (wb_val_B && wb_slot_B == op_slot[k]) begin d = 1; v = wb_data_B; known = 1; end
      check($sformatf("op_done_%0d", k), 64'(op_done[k]), 64'(d));
      if (known) check($sformatf("op_data_%0d", k), 64'(op_data[k]), 64'(v));
    end
  endtask

  // Advance one edge, update the model with pre-edge inputs, check the registered outputs
  task automatic clk_edge();
    e_wen_a = cm_ready_A & cm_we_A & ~cm_spec_A & (cm_rd_A != 0);
    e_wen_b = cm_ready_B & cm_we_B & ~cm_spec_B & (cm_rd_B != 0);
    e_waddr_a = cm_rd_A;
    e_waddr_b = cm_rd_B;
    e_wdata_a = m_data[cm_slot_A]; e_wdata_a_ok = m_valid[cm_slot_A];
    e_wdata_b = m_data[cm_slot_B]; e_wdata_b_ok = m_valid[cm_slot_B];
    m_instret = m_instret + 64'(cm_ready_A & ~cm_spec_A) + 64'(cm_ready_B & ~cm_spec_B);
    if (cm_ready_A) m_done[cm_slot_A] = 0;
    if (cm_ready_B) m_done[cm_slot_B] = 0;
    if (wb_val_A) begin m_done[wb_slot_A] = 1; m_data[wb_slot_A] = wb_data_A; m_valid[wb_slot_A] = 1; end
    if (wb_val_B) begin m_done[wb_slot_B] = 1; m_data[wb_slot_B] = wb_data_B; m_valid[wb_slot_B] = 1; end
    @(posedge clk);
    #1;
    check("rf_wen_A", 64'(rf_wen_A), 64'(e_wen_a));
    check("rf_wen_B", 64'(rf_wen_B), 64'(e_wen_b));
    check("rf_waddr_A", 64'(rf_waddr_A), 64'(e_waddr_a));
    check("rf_waddr_B", 64'(rf_waddr_B), 64'(e_waddr_b));
    if (e_wdata_a_ok) check("rf_wdata_A", 64'(rf_wdata_A), 64'(e_wdata_a));
    if (e_wdata_b_ok) check("rf_wdata_B", 64'(rf_wdata_B), 64'(e_wdata_b));
`ifdef RISCV_RETIRE_INSTRET_EN
    check("instret", instret, m_instret);
`endif
  endtask

  task automatic rand_cycle();
    wb_val_A = 1'($urandom % 2);
    wb_val_B = 1'($urandom % 2);
    wb_slot_A = 5'($urandom);
    wb_slot_B = ($urandom % 4 == 0) ? wb_slot_A : 5'($urandom);
    wb_data_A = $urandom;
    wb_data_B = $urandom;
    cm_ready_A = 1'($urandom % 2);
    cm_ready_B = cm_ready_A ? 1'($urandom % 2) : 1'($urandom % 8 == 0);
    cm_slot_A = ($urandom % 4 == 0) ? wb_slot_A : 5'($urandom);
    cm_slot_B = 5'($urandom);
    cm_rd_A = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
    cm_rd_B = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
    cm_we_A = 1'($urandom % 4 != 0);
    cm_we_B = 1'($urandom % 4 != 0);
    cm_spec_A = 1'($urandom % 4 == 0);
    cm_spec_B = 1'($urandom % 4 == 0);
    for (int k = 0; k < 4; k++)
      op_slot[k] = ($urandom % 3 == 0) ? (k[0] ? wb_slot_B : wb_slot_A) : 5'($urandom);
    settle();
    clk_edge();
  endtask

  initial begin
    logic [63:0] i0;
    for (int s = 0; s < 32; s++) begin m_valid[s] = 0; m_done[s] = 0; m_data[s] = 0; end
    m_instret = 0;
    idle();
    for (int k = 0; k < 4; k++) op_slot[k] = 5'(k);
    reset = 0;
    #2;
    check("rst_wen_A", 64'(rf_wen_A), 64'd0);
    check("rst_wen_B", 64'(rf_wen_B), 64'd0);
    check("rst_wdata_A", 64'(rf_wdata_A), 64'd0);
    #10 reset = 1;

    // Fill every slot once so data contents are known
    for (int i = 0; i < 16; i++) begin
      idle();
      wb_val_A = 1; wb_slot_A = 5'(2 * i);     wb_data_A = $urandom;
      wb_val_B = 1; wb_slot_B = 5'(2 * i + 1); wb_data_B = $urandom;
      settle();
      clk_edge();
    end

    // Writeback then retire two cycles later
    idle();
    wb_val_A = 1; wb_slot_A = 4; wb_data_A = 32'hDEADBEEF;
    settle();
    check("dir_req_A", 64'(rob_commit_req_A), 64'd1);
    check("dir_slot_A", 64'(rob_commit_slot_A), 64'd4);
    clk_edge();
    idle(); settle(); clk_edge();
    cm_ready_A = 1; cm_slot_A = 4; cm_rd_A = 7; cm_we_A = 1;
    settle(); clk_edge();
    check("dir_wen_A", 64'(rf_wen_A), 64'd1);
    check("dir_waddr_A", 64'(rf_waddr_A), 64'd7);
    check("dir_wdata_A", 64'(rf_wdata_A), 64'hDEADBEEF);
    idle(); op_slot[0] = 4;
    settle();
    check("dir_done4_clr", 64'(op_done[0]), 64'd0);
    clk_edge();
    check("dir_wen_pulse", 64'(rf_wen_A), 64'd0);

    // Dual retire of slots 30/31
    idle();
    wb_val_A = 1; wb_slot_A = 30; wb_data_A = 32'h11;
    wb_val_B = 1; wb_slot_B = 31; wb_data_B = 32'h22;
    settle(); clk_edge();
    idle();
    cm_ready_A = 1; cm_slot_A = 30; cm_rd_A = 5; cm_we_A = 1;
    cm_ready_B = 1; cm_slot_B = 31; cm_rd_B = 6; cm_we_B = 1;
    i0 = m_instret;
    settle(); clk_edge();
    check("dual_wen_A", 64'(rf_wen_A), 64'd1);
    check("dual_wen_B", 64'(rf_wen_B), 64'd1);
    check("dual_waddr_B", 64'(rf_waddr_B), 64'd6);
    check("dual_wdata_A", 64'(rf_wdata_A), 64'h11);
    check("dual_wdata_B", 64'(rf_wdata_B), 64'h22);
`ifdef RISCV_RETIRE_INSTRET_EN
    check("dual_instret", instret, i0 + 64'd2);
`endif

    // Squashed retire, then write to x0
    idle();
    cm_ready_A = 1; cm_slot_A = 10; cm_rd_A = 9; cm_we_A = 1; cm_spec_A = 1;
    i0 = m_instret;
    settle(); clk_edge();
    check("squash_wen", 64'(rf_wen_A), 64'd0);
`ifdef RISCV_RETIRE_INSTRET_EN
    check("squash_instret", instret, i0);
`endif
    idle();
    cm_ready_A = 1; cm_slot_A = 11; cm_rd_A = 0; cm_we_A = 1;
    i0 = m_instret;
    settle(); clk_edge();
    check("x0_wen", 64'(rf_wen_A), 64'd0);
`ifdef RISCV_RETIRE_INSTRET_EN
    check("x0_instret", instret, i0 + 64'd1);
`endif

    // Forwarding from pipe B
    idle();
    wb_val_B = 1; wb_slot_B = 12; wb_data_B = 32'h55; op_slot[2] = 12;
    settle();
    check("fwd_done", 64'(op_done[2]), 64'd1);
    check("fwd_data", 64'(op_data[2]), 64'h55);
    clk_edge();

    // Same-slot collision: B wins data, both pulses issued
    idle();
    wb_val_A = 1; wb_slot_A = 8; wb_data_A = 32'hA;
    wb_val_B = 1; wb_slot_B = 8; wb_data_B = 32'hB;
    op_slot[1] = 8;
    settle();
    check("col_req_A", 64'(rob_commit_req_A), 64'd1);
    check("col_req_B", 64'(rob_commit_req_B), 64'd1);
    check("col_fwd", 64'(op_data[1]), 64'hB);
    clk_edge();
    idle(); settle();
    check("col_data8", 64'(op_data[1]), 64'hB);

    // Writeback and retire on the same slot: retire sees old data, done stays set
    wb_val_A = 1; wb_slot_A = 8; wb_data_A = 32'hC0FFEE;
    cm_ready_A = 1; cm_slot_A = 8; cm_rd_A = 3; cm_we_A = 1;
    settle(); clk_edge();
    check("realloc_wdata", 64'(rf_wdata_A), 64'hB);
    idle(); settle();
    check("realloc_done", 64'(op_done[1]), 64'd1);
    check("realloc_data", 64'(op_data[1]), 64'hC0FFEE);
    clk_edge();

    for (int i = 0; i < 400; i++) rand_cycle();

    // Reset mid-run, asserted between edges
    idle();
    wb_val_A = 1; wb_slot_A = 3; wb_data_A = 32'h3333;
    cm_ready_A = 1; cm_slot_A = 3; cm_rd_A = 1; cm_we_A = 1;
    settle(); clk_edge();
    idle();
    wb_val_A = 1; wb_slot_A = 3; wb_data_A = 32'h4444;
    settle(); clk_edge();
    idle(); op_slot[0] = 3;
    wb_val_A = 1; wb_slot_A = 5;
    reset = 0;
    #1;
    check("mid_rst_req", 64'(rob_commit_req_A), 64'd0);
    check("mid_rst_wen_A", 64'(rf_wen_A), 64'd0);
    check("mid_rst_wen_B", 64'(rf_wen_B), 64'd0);
    wb_val_A = 0;
    #1;
    check("mid_rst_done3", 64'(op_done[0]), 64'd0);
    @(posedge clk);
    #2 reset = 1;
    for (int s = 0; s < 32; s++) m_done[s] = 0;
    m_instret = 0;
    #1;
    check("post_rst_done3", 64'(op_done[0]), 64'd0);
`ifdef RISCV_RETIRE_INSTRET_EN
    check("post_rst_instret", instret, 64'd0);
`endif
    @(negedge clk);
    for (int i = 0; i < 100; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
